// File: rtl/gobang_referee.sv
// gobang_referee: N-in-a-row referee with board store, move legality,
// turn rotation and a sequential four-direction line scan.
module gobang_referee #(
  parameter int BOARD_N = 16,
  parameter int WIN_LEN = 5,
  parameter int PLAYERS = 2,
  parameter int COORD_W = 4,
  parameter int CELL_W  = $clog2(PLAYERS + 1)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               put,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] rd_row,
  input  logic [COORD_W-1:0] rd_col,
  output logic [CELL_W-1:0]  rd_data,
  output logic [1:0]         turn,
  output logic               busy,
  output logic               accept,
  output logic               reject,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               draw,
  output logic [8:0]         move_count
);

  localparam int PW = COORD_W + 2;
  localparam int SW = 5;

  localparam logic [COORD_W:0] NLIM =
    (COORD_W + 1)'(BOARD_N);
  localparam logic signed [PW-1:0] NPOS =
    PW'(BOARD_N);
  localparam logic [SW-1:0] WINV    = SW'(WIN_LEN);
  localparam logic [SW-1:0] STEPMAX = SW'(WIN_LEN - 1);
  localparam logic [8:0]    CELLS   = 9'(BOARD_N * BOARD_N);
  localparam logic [1:0]    LASTP   = 2'(PLAYERS - 1);

  localparam logic signed [PW-1:0] P_ONE =
    {{(PW-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] M_ONE = '1;
  localparam logic signed [PW-1:0] ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OVER
  } state_e;

  state_e state_q, state_d;

  logic [CELL_W-1:0] board_q [BOARD_N][BOARD_N];
  logic [CELL_W-1:0] rd_data_q;

  logic              put_q;
  logic [1:0]        turn_q, turn_d;
  logic              busy_q, busy_d;
  logic              accept_q, accept_d;
  logic              reject_q, reject_d;
  logic              over_q, over_d;
  logic [1:0]        winner_q, winner_d;
  logic              draw_q, draw_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [COORD_W-1:0] mr_q, mr_d;
  logic [COORD_W-1:0] mc_q, mc_d;
  logic [1:0]        dir_q, dir_d;
  logic              neg_q, neg_d;
  logic [SW-1:0]     step_q, step_d;
  logic [SW-1:0]     run_q, run_d;
  logic signed [PW-1:0] cr_q, cr_d;
  logic signed [PW-1:0] cc_q, cc_d;

  logic              put_edge;
  logic              we;
  logic              mv_in;
  logic              legal;
  logic              rd_in;
  logic [CELL_W-1:0] code;
  logic signed [PW-1:0] dr, dc;
  logic signed [PW-1:0] nr, nc;
  logic signed [PW-1:0] home_r, home_c;
  logic              inb;
  logic              hit;
  logic [CELL_W-1:0] ncell;

  assign put_edge = put & ~put_q;
  assign code     = CELL_W'(turn_q) + CELL_W'(1);

  assign mv_in = ({1'b0, row} < NLIM) &&
                 ({1'b0, col} < NLIM);
  assign legal = mv_in && !over_q &&
                 (board_q[row][col] == '0);
  assign rd_in = ({1'b0, rd_row} < NLIM) &&
                 ({1'b0, rd_col} < NLIM);

  assign home_r = signed'({2'b00, mr_q});
  assign home_c = signed'({2'b00, mc_q});

  // Step vector for the current direction and sense.
  always_comb begin
    dr = ZERO;
    dc = ZERO;
    unique case (dir_q)
      2'd0: begin dr = ZERO;  dc = P_ONE; end
      2'd1: begin dr = P_ONE; dc = ZERO;  end
      2'd2: begin dr = P_ONE; dc = P_ONE; end
      default: begin dr = P_ONE; dc = M_ONE; end
    endcase
    if (neg_q) begin
      dr = -dr;
      dc = -dc;
    end
  end

  assign nr = cr_q + dr;
  assign nc = cc_q + dc;

  assign inb = !nr[PW-1] && (nr < NPOS) &&
               !nc[PW-1] && (nc < NPOS);

  assign ncell =
    board_q[nr[COORD_W-1:0]][nc[COORD_W-1:0]];

  assign hit = inb && (ncell == code) &&
               (step_q < STEPMAX);

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    busy_d   = busy_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    over_d   = over_q;
    winner_d = winner_q;
    draw_d   = draw_q;
    cnt_d    = cnt_q;
    mr_d     = mr_q;
    mc_d     = mc_q;
    dir_d    = dir_q;
    neg_d    = neg_q;
    step_d   = step_q;
    run_d    = run_q;
    cr_d     = cr_q;
    cc_d     = cc_q;
    we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (put_edge) begin
          if (legal) begin
            we      = 1'b1;
            cnt_d   = cnt_q + 9'd1;
            busy_d  = 1'b1;
            mr_d    = row;
            mc_d    = col;
            cr_d    = signed'({2'b00, row});
            cc_d    = signed'({2'b00, col});
            dir_d   = 2'd0;
            neg_d   = 1'b0;
            step_d  = '0;
            run_d   = SW'(1);
            state_d = SCAN;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (hit) begin
          run_d  = run_q + SW'(1);
          step_d = step_q + SW'(1);
          cr_d   = nr;
          cc_d   = nc;
          if (run_d >= WINV) begin
            state_d  = OVER;
            over_d   = 1'b1;
            winner_d = turn_q;
            busy_d   = 1'b0;
          end
        end else if (!neg_q) begin
          neg_d  = 1'b1;
          step_d = '0;
          cr_d   = home_r;
          cc_d   = home_c;
        end else if (dir_q != 2'd3) begin
          dir_d  = dir_q + 2'd1;
          neg_d  = 1'b0;
          step_d = '0;
          run_d  = SW'(1);
          cr_d   = home_r;
          cc_d   = home_c;
        end else begin
          busy_d = 1'b0;
          if (cnt_q == CELLS) begin
            state_d = OVER;
            over_d  = 1'b1;
            draw_d  = 1'b1;
          end else begin
            state_d  = IDLE;
            accept_d = 1'b1;
            turn_d   = (turn_q == LASTP) ?
                       2'd0 : turn_q + 2'd1;
          end
        end
      end
      OVER: begin
        reject_d = put_edge;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      put_q    <= 1'b0;
      turn_q   <= '0;
      busy_q   <= 1'b0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= '0;
      draw_q   <= 1'b0;
      cnt_q    <= '0;
      mr_q     <= '0;
      mc_q     <= '0;
      dir_q    <= '0;
      neg_q    <= 1'b0;
      step_q   <= '0;
      run_q    <= '0;
      cr_q     <= '0;
      cc_q     <= '0;
    end else begin
      state_q  <= state_d;
      put_q    <= put;
      turn_q   <= turn_d;
      busy_q   <= busy_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
      cnt_q    <= cnt_d;
      mr_q     <= mr_d;
      mc_q     <= mc_d;
      dir_q    <= dir_d;
      neg_q    <= neg_d;
      step_q   <= step_d;
      run_q    <= run_d;
      cr_q     <= cr_d;
      cc_q     <= cc_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BOARD_N; i++) begin
        for (int j = 0; j < BOARD_N; j++) begin
          board_q[i][j] <= '0;
        end
      end
    end else if (we) begin
      board_q[row][col] <= code;
    end
  end

  // Display port runs regardless of FSM state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_in ?
                   board_q[rd_row][rd_col] : '0;
    end
  end

  assign rd_data    = rd_data_q;
  assign turn       = turn_q;
  assign busy       = busy_q;
  assign accept     = accept_q;
  assign reject     = reject_q;
  assign game_over  = over_q;
  assign winner     = winner_q;
  assign draw       = draw_q;
  assign move_count = cnt_q;

endmodule

// File: tb/tb_gobang_referee.sv
// tb_gobang_referee: stimulus pushes expected move outcomes; monitors pop
// and compare whenever a referee pulses accept/reject or enters game over.
`timescale 1ns/1ps
module tb_gobang_referee;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] turn;
    logic [8:0] cnt;
    logic [1:0] win;
    logic       dr;
  } rsp_t;

  localparam logic [1:0] K_ACC = 2'd1;
  localparam logic [1:0] K_REJ = 2'd2;
  localparam logic [1:0] K_END = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       pa, pb;
  logic [3:0] ra, ca, rra, rca;
  logic [1:0] rb, cb, rrb, rcb;

  logic [1:0] rd_a, turn_a, win_a;
  logic       busy_a, acc_a, rej_a, go_a, draw_a;
  logic [8:0] cnt_a;
  logic [1:0] rd_b, turn_b, win_b;
  logic       busy_b, acc_b, rej_b, go_b, draw_b;
  logic [8:0] cnt_b;

  gobang_referee #(
    .BOARD_N(16), .WIN_LEN(5), .PLAYERS(2), .COORD_W(4)
  ) dut_a (
    .clock(clk), .resetn(rst_a), .put(pa),
    .row(ra), .col(ca), .rd_row(rra), .rd_col(rca),
    .rd_data(rd_a), .turn(turn_a), .busy(busy_a),
    .accept(acc_a), .reject(rej_a), .game_over(go_a),
    .winner(win_a), .draw(draw_a), .move_count(cnt_a)
  );

  gobang_referee #(
    .BOARD_N(3), .WIN_LEN(3), .PLAYERS(2), .COORD_W(2)
  ) dut_b (
    .clock(clk), .resetn(rst_b), .put(pb),
    .row(rb), .col(cb), .rd_row(rrb), .rd_col(rcb),
    .rd_data(rd_b), .turn(turn_b), .busy(busy_b),
    .accept(acc_b), .reject(rej_b), .game_over(go_b),
    .winner(win_b), .draw(draw_b), .move_count(cnt_b)
  );

  int checks = 0;
  int errors = 0;
  rsp_t qa[$];
  rsp_t qb[$];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic cmp(input string p, input rsp_t e,
                     input rsp_t o);
    chk({p, "_kind"}, o.kind, e.kind);
    chk({p, "_turn"}, o.turn, e.turn);
    chk({p, "_count"}, o.cnt, e.cnt);
    chk({p, "_winner"}, o.win, e.win);
    chk({p, "_draw"}, o.dr, e.dr);
  endtask

  function automatic rsp_t R(input logic [1:0] k,
                             input logic [1:0] t,
                             input int n,
                             input logic [1:0] w,
                             input logic d);
    rsp_t x;
    x.kind = k;
    x.turn = t;
    x.cnt  = 9'(n);
    x.win  = w;
    x.dr   = d;
    return x;
  endfunction

  logic go_pa = 1'b0;
  logic go_pb = 1'b0;
  rsp_t ea, eb, oa, ob;

  always @(negedge clk) begin
    if (rst_a && (acc_a || rej_a || (go_a && !go_pa))) begin
      oa = R(acc_a ? K_ACC : (rej_a ? K_REJ : K_END),
             turn_a, int'(cnt_a), win_a, draw_a);
      if (qa.size() == 0) begin
        chk("a_spurious_event", 1, 0);
      end else begin
        ea = qa.pop_front();
        cmp("a", ea, oa);
      end
    end
    go_pa = go_a;
  end

  always @(negedge clk) begin
    if (rst_b && (acc_b || rej_b || (go_b && !go_pb))) begin
      ob = R(acc_b ? K_ACC : (rej_b ? K_REJ : K_END),
             turn_b, int'(cnt_b), win_b, draw_b);
      if (qb.size() == 0) begin
        chk("b_spurious_event", 1, 0);
      end else begin
        eb = qb.pop_front();
        cmp("b", eb, ob);
      end
    end
    go_pb = go_b;
  end

  task automatic mv(input bit b, input int r, input int c,
                    input rsp_t e);
    int n;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
    @(posedge clk); #1;
    if (b) begin
      rb = 2'(r); cb = 2'(c); pb = 1'b1;
    end else begin
      ra = 4'(r); ca = 4'(c); pa = 1'b1;
    end
    @(posedge clk); #1;
    pa = 1'b0;
    pb = 1'b0;
    n = 0;
    while ((b ? busy_b : busy_a) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk(b ? "b_busy_timeout" : "a_busy_timeout",
        b ? busy_b : busy_a, 0);
    @(posedge clk); #1;
  endtask

  task automatic reset_a();
    @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk_a(input string nm, input int r,
                          input int c, input int want);
    rra = 4'(r);
    rca = 4'(c);
    @(posedge clk); #1;
    chk(nm, rd_a, want);
  endtask

  int g2r[16] = '{0, 12, 0, 12, 0, 14, 0, 14,
                  1, 10, 0, 10, 1, 10, 3, 10};
  int g2c[16] = '{12, 12, 13, 14, 14, 12, 15, 14,
                  0, 0, 4, 2, 3, 4, 1, 6};
  int gbr[9]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int gbc[9]  = '{0, 1, 2, 1, 0, 2, 1, 0, 2};

  initial begin
    int n;
    pa = 0; pb = 0;
    ra = 0; ca = 0; rra = 0; rca = 0;
    rb = 0; cb = 0; rrb = 0; rcb = 0;
    rst_a = 0; rst_b = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1;
    rst_b = 1;
    @(posedge clk); #1;

    chk("rst_turn", turn_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_accept", acc_a, 0);
    chk("rst_reject", rej_a, 0);
    chk("rst_game_over", go_a, 0);
    chk("rst_winner", win_a, 0);
    chk("rst_draw", draw_a, 0);
    chk("rst_move_count", cnt_a, 0);
    chk("rst_rd_data", rd_a, 0);
    chk("rst_b_move_count", cnt_b, 0);

    // Horizontal win for player 0 on row 7.
    for (int i = 0; i < 4; i++) begin
      mv(0, 7, 3 + i, R(K_ACC, 1, 2 * i + 1, 0, 0));
      mv(0, 0, i, R(K_ACC, 0, 2 * i + 2, 0, 0));
    end
    mv(0, 7, 7, R(K_END, 0, 9, 0, 0));
    mv(0, 5, 5, R(K_REJ, 0, 9, 0, 0));
    chk("h_game_over", go_a, 1);
    rd_chk_a("h_rd_p0", 7, 7, 1);
    rd_chk_a("h_rd_p1", 0, 3, 2);
    rd_chk_a("h_rd_empty", 8, 8, 0);

    reset_a();
    chk("h_reset_game_over", go_a, 0);

    // Occupied cell.
    mv(0, 2, 2, R(K_ACC, 1, 1, 0, 0));
    mv(0, 2, 2, R(K_REJ, 1, 1, 0, 0));

    // Held put plus a fresh edge while scanning.
    qa.push_back(R(K_ACC, 0, 2, 0, 0));
    @(posedge clk); #1;
    ra = 10; ca = 10; pa = 1;
    @(posedge clk); #1;
    pa = 0;
    chk("held_busy", busy_a, 1);
    @(posedge clk); #1;
    pa = 1;
    repeat (20) @(posedge clk);
    #1 pa = 0;
    n = 0;
    while (busy_a && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk("held_busy_timeout", busy_a, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_move_count", cnt_a, 2);

    // Row-end without wrap, then anti-diagonal win.
    for (int i = 0; i < 16; i++) begin
      mv(0, g2r[i], g2c[i],
         R(K_ACC, (i % 2 == 0) ? 2'd1 : 2'd0, 3 + i, 0, 0));
    end
    mv(0, 4, 0, R(K_END, 0, 19, 0, 0));
    rd_chk_a("d_rd_p0", 4, 0, 1);
    rd_chk_a("d_rd_p1", 10, 6, 2);

    reset_a();

    // Reset in the middle of a scan.
    rra = 5;
    rca = 5;
    @(posedge clk); #1;
    ra = 5; ca = 5; pa = 1;
    @(posedge clk); #1;
    pa = 0;
    chk("mid_busy", busy_a, 1);
    repeat (2) @(posedge clk);
    #1 rst_a = 0;
    #1;
    chk("mid_turn", turn_a, 0);
    chk("mid_busy_rst", busy_a, 0);
    chk("mid_accept", acc_a, 0);
    chk("mid_move_count", cnt_a, 0);
    chk("mid_rd_data", rd_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rd_after", rd_a, 0);
    chk("mid_count_after", cnt_a, 0);
    mv(0, 5, 5, R(K_ACC, 1, 1, 0, 0));
    rd_chk_a("mid_rd_placed", 5, 5, 1);

    // Small board: illegal coordinate, then fill to a draw.
    mv(1, 3, 0, R(K_REJ, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      mv(1, gbr[i], gbc[i],
         R(K_ACC, (i % 2 == 0) ? 2'd1 : 2'd0, i + 1, 0, 0));
    end
    mv(1, gbr[8], gbc[8], R(K_END, 0, 9, 0, 1));
    mv(1, 0, 0, R(K_REJ, 0, 9, 0, 1));
    chk("b_draw", draw_b, 1);
    chk("b_game_over", go_b, 1);
    chk("b_move_count", cnt_b, 9);
    rrb = 3;
    rcb = 1;
    @(posedge clk); #1;
    chk("b_rd_out_of_range", rd_b, 0);
    rrb = 1;
    rcb = 1;
    @(posedge clk); #1;
    chk("b_rd_centre", rd_b, 2);

    repeat (5) @(posedge clk);
    #1;
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
